// File: rtl/sub_normalize_seq.sv
// Final stage of the FP subtract datapath: one-bit-per-cycle left normalization,
// then round-to-nearest-even (or truncate), producing an IEEE-754 single word.
module sub_normalize_seq #(
    parameter logic ROUND_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [7:0]  exp_in,
    input  logic [25:0] frac_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] floating_point_out
);

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_sign;
    logic [7:0]  r_exp;
    logic [25:0] r_frac;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_frac_zero;
    logic        w_exp_low;
    logic        w_round_up;
    logic [24:0] w_mant_sum;
    logic [7:0]  w_exp_rnd;
    logic [22:0] w_mant_rnd;
    logic [31:0] w_rnd_result;

    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_frac_zero = (r_frac == 26'h0);
    assign w_exp_low   = (r_exp <= 8'd1);

    // Nearest-even: guard bit set and either sticky set or LSB odd.
    assign w_round_up  = ROUND_EN && r_frac[1] && (r_frac[0] || r_frac[2]);
    assign w_mant_sum  = {1'b0, r_frac[25:2]} + {24'd0, w_round_up};
    // A carry out means the mantissa wrapped to 1.0 with zero fraction bits.
    assign w_exp_rnd   = r_exp + {7'd0, w_mant_sum[24]};
    assign w_mant_rnd  = w_mant_sum[24] ? 23'h0 : w_mant_sum[22:0];
    assign w_rnd_result = (w_exp_rnd == 8'hFF) ? {r_sign, 8'hFF, 23'h0}
                                               : {r_sign, w_exp_rnd, w_mant_rnd};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = (exp_in == 8'hFF) ? S_DONE : S_NORM;
            end
            S_NORM: begin
                if (w_frac_zero)    w_next = S_DONE;
                else if (r_frac[25]) w_next = S_ROUND;
                else if (w_exp_low)  w_next = S_DONE;
            end
            S_ROUND: w_next = S_DONE;
            S_DONE: begin
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready           = (r_state == S_IDLE);
        out_valid          = (r_state == S_DONE);
        floating_point_out = r_result;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_sign   <= 1'b0;
            r_exp    <= 8'h0;
            r_frac   <= 26'h0;
            r_result <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign <= sign_in;
                        r_exp  <= exp_in;
                        r_frac <= frac_in;
                        if (exp_in == 8'hFF) r_result <= {sign_in, 8'hFF, frac_in[24:2]};
                    end
                end
                S_NORM: begin
                    if (w_frac_zero) begin
                        r_result <= 32'h0;
                    end else if (!r_frac[25]) begin
                        // Exponent floor of 1 stops the shift; flush to signed zero.
                        if (w_exp_low) begin
                            r_result <= {r_sign, 31'h0};
                        end else begin
                            r_frac <= {r_frac[24:0], 1'b0};
                            r_exp  <= r_exp - 8'd1;
                        end
                    end
                end
                S_ROUND: r_result <= w_rnd_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_normalize_seq.sv
// Randomized bench for sub_normalize_seq against an arithmetic reference model,
// plus directed rounding, boundary, backpressure and mid-operation reset cases.
module tb_sub_normalize_seq;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic [25:0] frac_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] floating_point_out;

    int n_cmp = 0;
    int n_err = 0;

    sub_normalize_seq #(.ROUND_EN(1'b1)) dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .exp_in(exp_in), .frac_in(frac_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .floating_point_out(floating_point_out)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: leading-zero count, exponent floor, then integer rounding.
    function automatic void model(input logic s, input logic [7:0] e, input logic [25:0] f,
                                  output logic [31:0] res, output int lat);
        int     lz;
        int     ee;
        longint m, mant, rem;
        if (e == 8'hFF) begin
            res = {s, 8'hFF, f[24:2]};
            lat = 1;
        end else if (f == 26'h0) begin
            res = 32'h0;
            lat = 2;
        end else begin
            lz = 0;
            while (f[25-lz] == 1'b0) lz++;
            if (lz == 0 || int'(e) > lz) begin
                ee   = int'(e) - lz;
                m    = longint'(f) << lz;
                mant = m / 4;
                rem  = m % 4;
                if (rem > 2 || (rem == 2 && (mant % 2) == 1)) mant++;
                if (mant == (longint'(1) << 24)) begin
                    mant = longint'(1) << 23;
                    ee++;
                end
                if (ee >= 255) res = {s, 8'hFF, 23'h0};
                else           res = {s, 8'(ee), 23'(mant)};
                lat = 3 + lz;
            end else begin
                res = {s, 31'h0};
                lat = 2 + ((e > 8'd1) ? int'(e) - 1 : 0);
            end
        end
    endfunction

    // Called at a negedge; returns just after the handshake edge.
    task automatic issue(input logic s, input logic [7:0] e, input logic [25:0] f);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge CLK);
            w++;
        end
        if (!in_ready) chk("in_ready timeout", {31'h0, in_ready}, 32'h1);
        sign_in  = s;
        exp_in   = e;
        frac_in  = f;
        in_valid = 1'b1;
        @(posedge CLK);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!out_valid && lat < 200);
    endtask

    task automatic finish_out(input int stall, input logic [31:0] exp_res);
        repeat (stall) begin
            @(negedge CLK);
            chk("stall valid", {31'h0, out_valid}, 32'h1);
            chk("stall data", floating_point_out, exp_res);
            chk("stall in_ready", {31'h0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        @(posedge CLK);
        #1 out_ready = 1'b0;
        @(negedge CLK);
        chk("valid drop", {31'h0, out_valid}, 32'h0);
    endtask

    task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                          input logic [25:0] f, input int stall);
        logic [31:0] exp_res;
        int          exp_lat;
        int          lat;
        model(s, e, f, exp_res, exp_lat);
        issue(s, e, f);
        wait_out(lat);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result"}, floating_point_out, exp_res);
        finish_out(stall, exp_res);
    endtask

    initial begin
        logic [31:0] r;
        int          l;
        logic        s;
        logic [7:0]  e;
        logic [25:0] f;
        int          sel;
        int          lz;

        nRST = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sign_in = 1'b0; exp_in = 8'h0; frac_in = 26'h0;
        #1;
        chk("reset out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset in_ready", {31'h0, in_ready}, 32'h1);
        chk("reset data", floating_point_out, 32'h0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        // Directed results checked against hand-derived constants as well.
        run_op("8.0", 1'b0, 8'd130, 26'h2000000, 0);
        chk("8.0 const", floating_point_out, 32'h41000000);
        run_op("-2.0", 1'b1, 8'd130, 26'h0800000, 0);
        chk("-2.0 const", floating_point_out, 32'hC0000000);
        run_op("zero", 1'b1, 8'd130, 26'h0, 0);
        chk("zero const", floating_point_out, 32'h00000000);
        run_op("tie odd", 1'b0, 8'd127, {1'b1, 23'h000001, 2'b10}, 0);
        chk("tie odd const", floating_point_out, 32'h3F800002);
        run_op("tie even", 1'b0, 8'd127, {1'b1, 23'h0, 2'b10}, 0);
        chk("tie even const", floating_point_out, 32'h3F800000);
        run_op("carry", 1'b0, 8'd127, 26'h3FFFFFF, 0);
        chk("carry const", floating_point_out, 32'h40000000);
        run_op("underflow", 1'b1, 8'd1, 26'h1000000, 0);
        chk("underflow const", floating_point_out, 32'h80000000);
        run_op("overflow", 1'b0, 8'd254, 26'h3FFFFFF, 0);
        chk("overflow const", floating_point_out, 32'h7F800000);
        run_op("exp ff", 1'b1, 8'hFF, 26'h1234567, 0);
        run_op("backpressure", 1'b0, 8'd100, 26'h0345678, 10);

        // A new operand offered together with the output handshake must wait a cycle.
        model(1'b0, 8'd140, 26'h1800000, r, l);
        issue(1'b0, 8'd150, 26'h2000001);
        wait_out(l);
        sign_in = 1'b0; exp_in = 8'd140; frac_in = 26'h1800000;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge CLK);
        #1 out_ready = 1'b0;
        @(negedge CLK);
        chk("overlap valid", {31'h0, out_valid}, 32'h0);
        chk("overlap in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge CLK);
        #1 in_valid = 1'b0;
        model(1'b0, 8'd140, 26'h1800000, r, sel);
        wait_out(l);
        chk("overlap latency", 32'(l), 32'(sel));
        chk("overlap result", floating_point_out, r);
        finish_out(0, r);

        // Reset in the middle of a 20-shift normalization.
        issue(1'b0, 8'd130, 26'h0000020);
        repeat (5) @(negedge CLK);
        nRST = 1'b0;
        #1;
        chk("abort out_valid", {31'h0, out_valid}, 32'h0);
        chk("abort in_ready", {31'h0, in_ready}, 32'h1);
        chk("abort data", floating_point_out, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        run_op("after reset", 1'b0, 8'd130, 26'h0000020, 0);
        chk("after reset const", floating_point_out, 32'h37000000);

        for (int i = 0; i < 250; i++) begin
            s   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel == 0)      e = 8'hFF;
            else if (sel == 1) e = 8'($urandom_range(0, 3));
            else if (sel == 2) e = 8'($urandom_range(250, 254));
            else               e = 8'($urandom_range(1, 254));
            lz = $urandom_range(0, 26);
            f  = 26'($urandom) | 26'h2000000;
            f  = f >> lz;
            if ($urandom_range(0, 3) == 0) f[1:0] = 2'b10;
            run_op("random", s, e, f, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sub_normalize_seq.md
Name: sub_normalize_seq

Overview:
- Final (normalize/round) stage of the floating-point subtraction datapath, the counterpart of the alignment stage.
- Accepts the sign, the larger exponent and the 26-bit difference magnitude (hidden bit, 23 fraction bits, 2 guard bits).
- Normalizes iteratively with a one-bit left shift per cycle, then rounds, and emits an IEEE-754 single-precision word.
- Uses a valid/ready handshake on both sides; holds one operation at a time.

Parameters:
- ROUND_EN, 1, 1 = round-to-nearest-even using guard bits; 0 = truncate (guard bits dropped).

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- sign_in  input  1  sign of the difference.
- exp_in  input  8  biased exponent (max of the two operands).
- frac_in  input  26  magnitude; [25] hidden-bit position, [24:2] fraction, [1:0] guard/sticky.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- floating_point_out  output  32  IEEE single result.

Behaviour:
- Reset (async, nRST=0): state IDLE, in_ready=1, out_valid=0, floating_point_out=32'h0, internal registers cleared. Reset mid-operation aborts the operation and discards it.
- States: IDLE, NORM, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch sign/exp/frac and go to NORM.
  - If exp_in==8'hFF: the result is {sign_in, 8'hFF, frac_in[24:2]}, placed straight into DONE.
- NORM: in_ready=0. Conditions are checked in this priority, one decision per cycle:
  1. frac==0: result 32'h00000000 (+0 regardless of sign); go to DONE.
  2. frac[25]==1: go to ROUND.
  3. exp<=1: underflow; result {sign,31'h0}; go to DONE.
  4. Otherwise frac<<=1 (zero fill) and exp-=1; stay in NORM.
- ROUND:
  - With ROUND_EN=1: round up when frac[1] && (frac[0] || frac[2]); mantissa24 = frac[25:2] + up.
  - Carry out of mantissa24 (all ones + 1): mantissa becomes 24'h800000 and exp+=1.
  - If the resulting exp==8'hFF: result {sign, 8'hFF, 23'h0} (infinity).
  - Otherwise result = {sign, exp, mantissa24[22:0]}. Go to DONE.
- DONE: out_valid=1, floating_point_out stable.
  - On out_ready=1: go to IDLE and drop out_valid the next cycle.
  - While out_ready=0: hold indefinitely.
  - in_ready stays 0 until IDLE. No input is accepted in the same cycle as the output handshake.
- Latency, counted from the input handshake cycle to the first out_valid cycle:
  - normalized input: 3 cycles;
  - each leading zero in frac: +1 cycle (maximum 25 shifts);
  - zero input: 2 cycles;
  - exp_in==8'hFF: 1 cycle.
- floating_point_out is registered and is only meaningful while out_valid=1. It keeps its last value otherwise.
- Exponent arithmetic is 8-bit unsigned. The exp<=1 check prevents a decrement below 1.

Test Plan:
- sign 0, exp 8'd130, frac 26'h2000000 -> out 32'h41000000 (8.0), out_valid 3 cycles after the handshake.
- sign 1, exp 8'd130, frac 26'h0800000 -> two shifts, out 32'hC0000000 (-2.0), latency 5. Then frac 26'h0 -> out 32'h00000000, latency 2.
- Rounding with ROUND_EN=1, exp 8'd127:
  - frac {1'b1, 23'h000001, 2'b10} -> 32'h3F800002 (tie, odd LSB rounds up);
  - frac {1'b1, 23'h0, 2'b10} -> 32'h3F800000 (tie, even LSB stays);
  - frac 26'h3FFFFFF -> 32'h40000000 (carry, exp+1).
- Boundary exponents:
  - exp 8'd1, frac 26'h1000000, sign 1 -> 32'h80000000 (underflow flush);
  - exp 8'd254, frac 26'h3FFFFFF -> 32'h7F800000 (overflow to infinity).
- Backpressure: hold out_ready=0 for 10 cycles. out_valid and data stay stable and in_ready stays 0. A new in_valid is only accepted the cycle after out_ready=1.
- Reset: deassert nRST during NORM of a 20-shift operation. out_valid=0 and in_ready=1 immediately. After release, the next operation completes with the correct result.
